// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl: compares two WIDTH-bit operands two bits per cycle,
// MSB slice first, and reports registered g/e/l plus a one-cycle done pulse.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN: leave RUN at the first unequal slice.
module serial_compare_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             e,
  output logic             l
);

  localparam int unsigned NSL = WIDTH / 2;
  localparam int unsigned IW  = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic             busy_nxt;
  logic             done_nxt;

  logic [1:0]       a_sl_c;
  logic [1:0]       b_sl_c;
  logic             last_c;
  logic             diff_c;
  logic             decided_c;

  // Current 2-bit slice selected by the index, plus slice status flags
  assign a_sl_c    = 2'(a_q >> {idx, 1'b0});
  assign b_sl_c    = 2'(b_q >> {idx, 1'b0});
  assign last_c    = (idx == '0);
  assign diff_c    = (a_sl_c != b_sl_c);
  assign decided_c = g | l;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (last_c || diff_c) state_nxt = DONE;
`else
        if (last_c) state_nxt = DONE;
`endif
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode: busy tracks RUN exactly, done trails the DONE state by a cycle
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    if (state_nxt == RUN) busy_nxt = 1'b1;
    if (state == DONE)    done_nxt = 1'b1;
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // Operand capture, slice index and sticky first-difference verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      idx <= '0;
      g   <= 1'b0;
      e   <= 1'b0;
      l   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
            idx <= IW'(NSL - 1);
            g   <= 1'b0;
            e   <= 1'b0;
            l   <= 1'b0;
          end
        end
        RUN: begin
          if (!last_c) idx <= idx - IW'(1);
          if (!decided_c) begin
            if (a_sl_c > b_sl_c) begin
              g <= 1'b1;
            end else if (a_sl_c < b_sl_c) begin
              l <= 1'b1;
            end else if (last_c) begin
              e <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Bench for serial_compare_ctrl (WIDTH=8); honours SERIAL_CMP_EARLY_EXIT_EN.
module tb_serial_compare_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         g;
  logic         e;
  logic         l;

  int n_chk = 0;
  int n_err = 0;

  serial_compare_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .g     (g),
    .e     (e),
    .l     (l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Edges from acceptance to the edge after which done is seen
  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int k = 1; k <= int'(W / 2); k++) begin
      if ((x >> (W - 2 * k)) != (y >> (W - 2 * k))) return k + 1;
    end
`endif
    return int'(W / 2) + 1;
  endfunction

  task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input bit hold, input string tag);
    int  lat;
    int  seen;
    int  extra_done;
    logic [2:0] gel;
    lat  = exp_lat(ta, tb_v);
    gel  = {ta > tb_v, ta == tb_v, ta < tb_v};
    seen = 0;
    extra_done = 0;
    @(negedge clk);
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (hold) begin
      a = 8'h00;
      b = 8'hFF;
    end else begin
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
    end
    chk({tag, ":busy_at_accept"}, 32'(busy), 32'(1));
    for (int k = 1; k <= 20 && seen == 0; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen  = k;
        start = 1'b0;
      end else if (k < 4 || k >= lat - 1) begin
        chk({tag, ":busy_run"}, 32'(busy), 32'(k < lat - 1));
      end
    end
    chk({tag, ":latency"}, 32'(seen), 32'(lat));
    chk({tag, ":busy_at_done"}, 32'(busy), 32'(0));
    chk({tag, ":gel"}, 32'({g, e, l}), 32'(gel));
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) extra_done++;
    end
    chk({tag, ":no_second_done"}, 32'(extra_done), 32'(0));
    chk({tag, ":gel_hold"}, 32'({g, e, l}), 32'(gel));
  endtask

  initial begin
    int ndone;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #1;
    chk("reset_outputs", 32'({busy, done, g, e, l}), 32'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_cmp(8'hA5, 8'hA5, 1'b0, "eq_A5");
    run_cmp(8'h80, 8'h7F, 1'b0, "gt_80_7F");
    run_cmp(8'h12, 8'h13, 1'b0, "lt_12_13");
    run_cmp(8'h5A, 8'h5B, 1'b1, "hold_start");
    run_cmp(8'h00, 8'hFF, 1'b0, "second_after_hold");

    // Reset two cycles into RUN discards the comparison
    @(negedge clk);
    a = 8'h5A;
    b = 8'h3C;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", 32'({busy, done, g, e, l}), 32'(0));
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    chk("midrun_reset_no_done", 32'(ndone), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_cmp(8'h03, 8'h01, 1'b0, "post_reset_gt");

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = (i % 4 == 0) ? ra : ((i % 4 == 1) ? (ra ^ W'(1 << $urandom_range(0, W - 1))) : W'($urandom));
      run_cmp(ra, rb, bit'(i % 6 == 5), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
